// File: rtl/rv_fanout_pkg.sv
// Shared defaults and helpers for the rv_fanout_fifo track buffer.
package rv_fanout_pkg;

    localparam int DEFAULT_DATA_WIDTH = 17;
    localparam int DEFAULT_NUM_DEST   = 20;
    localparam int DEFAULT_DEPTH      = 2;
    localparam int STALL_CNT_W        = 16;

    // Pointer width for a power-of-2 depth; never collapses to zero bits.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rv_fanout_served_tracker.sv
// Per-destination served mask for the FIFO head; decides when every
// enabled destination has taken the head word so it can be retired.
module rv_fanout_served_tracker
    import rv_fanout_pkg::*;
#(
    parameter int NUM_DEST = DEFAULT_NUM_DEST
) (
    input  logic                CLK,
    input  logic                ASYNCRESET,
    input  logic [NUM_DEST-1:0] dest_en,
    input  logic [NUM_DEST-1:0] out_ready,
    input  logic                head_valid,
    output logic [NUM_DEST-1:0] out_valid,
    output logic                pop
);

    logic [NUM_DEST-1:0] served_q;
    logic [NUM_DEST-1:0] served_d;
    logic [NUM_DEST-1:0] acc;
    logic [NUM_DEST-1:0] done;

    always_comb begin
        out_valid = {NUM_DEST{head_valid}} & dest_en & ~served_q;
        acc       = out_valid & out_ready;
        // A destination dropped from dest_en stops blocking the head at once.
        done      = ~dest_en | served_q | acc;
        pop       = head_valid & (&done);
        served_d  = served_q | acc;
        if (pop) begin
            served_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            served_q <= '0;
        end else begin
            served_q <= served_d;
        end
    end

endmodule

// File: rtl/rv_fanout_fifo.sv
// Registered ready-valid fanout buffer for one interconnect track.
// Optional saturating head-stall counter: define RV_FANOUT_FIFO_STALL_CNT_EN.
module rv_fanout_fifo
    import rv_fanout_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_DEST   = DEFAULT_NUM_DEST,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESET,
`ifdef RV_FANOUT_FIFO_STALL_CNT_EN
    input  logic                   stall_clr,
    output logic [STALL_CNT_W-1:0] stall_count,
`endif
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_DEST-1:0]    dest_en,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [NUM_DEST-1:0]    out_valid,
    input  logic [NUM_DEST-1:0]    out_ready
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] last_q;
    logic [DATA_WIDTH-1:0] last_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  head_valid;
    logic                  push;
    logic                  pop;

    rv_fanout_served_tracker #(
        .NUM_DEST (NUM_DEST)
    ) u_tracker (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .dest_en    (dest_en),
        .out_ready  (out_ready),
        .head_valid (head_valid),
        .out_valid  (out_valid),
        .pop        (pop)
    );

    // in_ready comes from count_q only, so no ready path crosses the track.
    always_comb begin
        head_valid = (count_q != '0);
        in_ready   = (count_q != FULL_CNT);
        push       = in_valid & in_ready;
        out_data   = head_valid ? mem_q[rd_ptr_q] : last_q;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
            end
            last_q   <= last_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef RV_FANOUT_FIFO_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (head_valid && !pop && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rv_fanout_fifo.sv
// Directed bench for rv_fanout_fifo with hand-computed expectations.
module tb_rv_fanout_fifo;

    localparam int DW = 17;
    localparam int ND = 20;

    logic          CLK;
    logic          ASYNCRESET;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [ND-1:0] dest_en;
    logic [DW-1:0] out_data;
    logic [ND-1:0] out_valid;
    logic [ND-1:0] out_ready;
`ifdef RV_FANOUT_FIFO_STALL_CNT_EN
    logic          stall_clr;
    logic [15:0]   stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    rv_fanout_fifo dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
`ifdef RV_FANOUT_FIFO_STALL_CNT_EN
        .stall_clr  (stall_clr),
        .stall_count(stall_count),
`endif
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dest_en    (dest_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        ASYNCRESET = 1'b1;
        tick();
        tick();
        ASYNCRESET = 1'b0;
        tick();
    endtask

    initial begin
        ASYNCRESET = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        dest_en    = '0;
        out_ready  = '0;
`ifdef RV_FANOUT_FIFO_STALL_CNT_EN
        stall_clr  = 1'b0;
`endif
        do_reset();

        // reset state
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_data", 32'(out_data), 32'h0);

        // 1: reset mid-transfer with two words buffered
        dest_en = 20'h00001; out_ready = '0;
        in_valid = 1'b1; in_data = 17'h00111; tick();
        in_data = 17'h00222; tick();
        in_valid = 1'b0;
        check("t1_full", 32'(in_ready), 32'h0);
        check("t1_head", 32'(out_data), 32'h00111);
        #1 ASYNCRESET = 1'b1;
        #1;
        check("t1_async_valid", 32'(out_valid), 32'h0);
        check("t1_async_ready", 32'(in_ready), 32'h1);
        check("t1_async_data", 32'(out_data), 32'h0);
        #1 ASYNCRESET = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 17'h000A5; tick();
        in_valid = 1'b0;
        check("t1_first_valid", 32'(out_valid), 32'h1);
        check("t1_first_data", 32'(out_data), 32'h000A5);
        out_ready = 20'h00001; tick();
        out_ready = '0;
        check("t1_drained", 32'(out_valid), 32'h0);
        check("t1_hold_data", 32'(out_data), 32'h000A5);

        // 2: mixed ready timing
        dest_en = 20'h00003;
        in_valid = 1'b1; in_data = 17'h01001; tick();
        check("t2_c1_valid", 32'(out_valid), 32'h3);
        check("t2_c1_data", 32'(out_data), 32'h01001);
        in_data = 17'h01002; out_ready = 20'h00001; tick();
        in_valid = 1'b0;
        check("t2_c2_valid", 32'(out_valid), 32'h2);
        check("t2_c2_full", 32'(in_ready), 32'h0);
        tick();
        check("t2_c3_valid", 32'(out_valid), 32'h2);
        tick();
        check("t2_c4_valid", 32'(out_valid), 32'h2);
        check("t2_c4_data", 32'(out_data), 32'h01001);
        out_ready = 20'h00003; tick();
        check("t2_c5_valid", 32'(out_valid), 32'h3);
        check("t2_c5_data", 32'(out_data), 32'h01002);
        check("t2_c5_ready", 32'(in_ready), 32'h1);
        tick();
        out_ready = '0;
        check("t2_empty", 32'(out_valid), 32'h0);

        // 3: fill, hold third upstream, drain in order
        dest_en = 20'h00001;
        in_valid = 1'b1; in_data = 17'h00001; tick();
        check("t3_one_ready", 32'(in_ready), 32'h1);
        in_data = 17'h00002; tick();
        check("t3_full", 32'(in_ready), 32'h0);
        in_data = 17'h00003; tick();
        check("t3_held", 32'(in_ready), 32'h0);
        check("t3_head1", 32'(out_data), 32'h00001);
        out_ready = 20'h00001; tick();
        check("t3_head2", 32'(out_data), 32'h00002);
        check("t3_ready_back", 32'(in_ready), 32'h1);
        check("t3_valid2", 32'(out_valid), 32'h1);
        tick();
        in_valid = 1'b0;
        check("t3_head3", 32'(out_data), 32'h00003);
        check("t3_valid3", 32'(out_valid), 32'h1);
        tick();
        out_ready = '0;
        check("t3_empty", 32'(out_valid), 32'h0);
        check("t3_hold", 32'(out_data), 32'h00003);

        // 4: no destinations enabled, every word drains after one cycle
        dest_en = '0;
        in_valid = 1'b1; in_data = 17'h000AA; tick();
        check("t4_data_a", 32'(out_data), 32'h000AA);
        check("t4_valid_a", 32'(out_valid), 32'h0);
        in_data = 17'h000BB; tick();
        check("t4_data_b", 32'(out_data), 32'h000BB);
        check("t4_ready_b", 32'(in_ready), 32'h1);
        in_data = 17'h000CC; tick();
        in_valid = 1'b0;
        check("t4_data_c", 32'(out_data), 32'h000CC);
        check("t4_ready_c", 32'(in_ready), 32'h1);
        tick();
        check("t4_hold", 32'(out_data), 32'h000CC);
        check("t4_valid_end", 32'(out_valid), 32'h0);

        // 5: dropping the last pending destination pops the head that cycle
        dest_en = 20'h00006;
        in_valid = 1'b1; in_data = 17'h00155; tick();
        check("t5_valid_both", 32'(out_valid), 32'h6);
        in_data = 17'h00166; out_ready = 20'h00002; tick();
        in_valid = 1'b0; out_ready = '0;
        check("t5_served1", 32'(out_valid), 32'h4);
        check("t5_full", 32'(in_ready), 32'h0);
        dest_en = 20'h00002;
        #1;
        check("t5_drop_valid", 32'(out_valid), 32'h0);
        tick();
        check("t5_next_data", 32'(out_data), 32'h00166);
        check("t5_next_valid", 32'(out_valid), 32'h2);
        check("t5_next_ready", 32'(in_ready), 32'h1);
        // destination 2 joins mid-head and must accept before the pop
        dest_en = 20'h00006; out_ready = 20'h00002; tick();
        check("t5_join_valid", 32'(out_valid), 32'h4);
        check("t5_join_data", 32'(out_data), 32'h00166);
        out_ready = 20'h00004; tick();
        out_ready = '0;
        check("t5_join_done", 32'(out_valid), 32'h0);

`ifdef RV_FANOUT_FIFO_STALL_CNT_EN
        // 6: stall counter
        do_reset();
        check("t6_rst", 32'(stall_count), 32'h0);
        dest_en = 20'h00001; out_ready = '0;
        in_valid = 1'b1; in_data = 17'h00042; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t6_ten", 32'(stall_count), 32'd10);
        stall_clr = 1'b1; tick();
        stall_clr = 1'b0;
        check("t6_clr", 32'(stall_count), 32'h0);
        for (int i = 0; i < 70000; i++) tick();
        check("t6_sat", 32'(stall_count), 32'h0000FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
